secure_reg_access_master: RTL and testbench
===========================================

Name: secure_reg_access_master

Overview:
- Initiator side of the secure register access interface.
- Accepts thread-tagged read/write requests on a valid/ready port and enforces the thread-0-only policy before anything reaches the register.
- Drives the register's access_en/wr_en/thread_id/data_in pins, captures read data and returns a response tagged granted or denied.
- Sits between the per-thread request fabric and one secure register instance.

Parameters:
- DATA_WIDTH, 32, width of request/response data and register data.
- VIOL_CNT_WIDTH, 8, width of the saturating violation counter.
- LOCKOUT_THRESH, 4, violation count that triggers lockout (used only with the optional feature).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  master can accept a request
- req_write  input  1  1 = write, 0 = read
- req_thread_id  input  1  requesting thread id
- req_data  input  DATA_WIDTH  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  DATA_WIDTH  read data; 0 for writes and denials
- rsp_denied  output  1  request rejected by policy
- reg_access_en  output  1  register access strobe
- reg_wr_en  output  1  register write enable
- reg_thread_id  output  1  thread id presented to register
- reg_data_in  output  DATA_WIDTH  write data to register
- reg_data_out  input  DATA_WIDTH  register read data, valid the cycle after the access strobe
- viol_count  output  VIOL_CNT_WIDTH  saturating count of denied requests
- locked  output  1  lockout active

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE; all outputs 0 except req_ready, which is 1 in the first cycle after reset deasserts.
- FSM states are IDLE, ISSUE, WAIT, RESP. Only one request is outstanding at a time.
- IDLE:
  - req_ready=1.
  - On req_valid, capture write/thread_id/data (cycle T).
  - If thread_id!=0, or locked=1: go to RESP with rsp_denied=1, rsp_data=0, and increment viol_count (saturates at all-ones, no wrap).
  - Otherwise go to ISSUE.
- ISSUE (T+1):
  - reg_access_en=1, reg_wr_en=captured write, reg_thread_id=0, reg_data_in=captured data (0 for reads).
  - A write goes to RESP; a read goes to WAIT.
- WAIT (T+2): latch reg_data_out into rsp_data, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_denied held stable until rsp_ready.
  - When rsp_valid and rsp_ready are both high, go to IDLE with rsp_valid=0 next cycle.
- Latency, from accept to first rsp_valid cycle:
  - Denied: T+1.
  - Granted write: T+2.
  - Granted read: T+3.
- req_ready=0 in every state except IDLE; there is no new accept in the cycle a response handshakes.
- Security invariants:
  - reg_access_en is never 1 for a denied request.
  - reg_thread_id is always 0.
  - All reg_* outputs are 0 outside ISSUE.
  - A nonzero thread id never reaches the register.
- rst asserted in any state, including mid-ISSUE or mid-RESP:
  - Pending request discarded, no response produced.
  - All outputs 0, viol_count=0, locked=0.
- Holding rsp_ready low in RESP stalls indefinitely with no state change.

Optional Feature:
- Macro: SECURE_REG_VIOLATION_LOCKOUT_EN.
- Defined:
  - When viol_count reaches LOCKOUT_THRESH, locked goes 1 the next cycle and stays set until rst.
  - While locked, every request, including thread 0, is denied at T+1 with no register access.
  - Lockout denials do not increment viol_count.
- Undefined:
  - locked is tied 0 and there is no lockout logic.
  - viol_count keeps counting and saturating.

Test Plan:
1. Thread 0 write 0xDEADBEEF:
   - T+1: reg_access_en=1, reg_wr_en=1, reg_data_in=0xDEADBEEF, reg_thread_id=0.
   - T+2: rsp_valid=1, rsp_denied=0, rsp_data=0.
2. Thread 0 read with reg_data_out=0x12345678 at T+2 → T+3: rsp_valid=1, rsp_data=0x12345678, rsp_denied=0.
3. Thread 1 write 0xFFFFFFFF → reg_access_en stays 0 throughout; T+1: rsp_valid=1, rsp_denied=1, rsp_data=0; viol_count=1.
4. Response backpressure: rsp_ready held 0 for 5 cycles → rsp_valid, rsp_data and rsp_denied stable; req_ready=0; a new req_valid is ignored until the handshake.
5. rst pulsed during ISSUE of a thread 0 write → next cycle all outputs 0, no rsp_valid, viol_count=0, req_ready=1 after rst drops.
6. With SECURE_REG_VIOLATION_LOCKOUT_EN, 4 thread-1 requests → locked=1; then a thread 0 read → denied at T+1, no reg_access_en, viol_count stays 4. Without the macro: locked=0 and the thread 0 read is granted.

Source files
------------

// File: rtl/secure_reg_access_master.sv
// Initiator for the secure register: one request at a time, only thread 0 reaches the register.
// Optional lockout after repeated violations is enabled by defining SECURE_REG_VIOLATION_LOCKOUT_EN.
module secure_reg_access_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int VIOL_CNT_WIDTH = 8,
    parameter int LOCKOUT_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic                      req_thread_id,
    input  logic [DATA_WIDTH-1:0]     req_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_denied,
    output logic                      reg_access_en,
    output logic                      reg_wr_en,
    output logic                      reg_thread_id,
    output logic [DATA_WIDTH-1:0]     reg_data_in,
    input  logic [DATA_WIDTH-1:0]     reg_data_out,
    output logic [VIOL_CNT_WIDTH-1:0] viol_count,
    output logic                      locked
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      wr_q, wr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                      rsp_denied_q, rsp_denied_d;
    logic [VIOL_CNT_WIDTH-1:0] viol_q, viol_d;
    logic                      lock_active;

`ifdef SECURE_REG_VIOLATION_LOCKOUT_EN
    logic locked_q, locked_d;

    always_comb begin
        locked_d = locked_q | (viol_q >= VIOL_CNT_WIDTH'(LOCKOUT_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) locked_q <= 1'b0;
        else     locked_q <= locked_d;
    end

    assign lock_active = locked_q;
`else
    assign lock_active = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        rsp_denied_d = rsp_denied_q;
        viol_d       = viol_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_data_d = '0;
                    if (req_thread_id || lock_active) begin
                        state_d      = RESP;
                        rsp_denied_d = 1'b1;
                        // Lockout denials are not fresh violations, so they leave the count alone.
                        if (!lock_active && (viol_q != '1)) viol_d = viol_q + 1'b1;
                    end else begin
                        state_d      = ISSUE;
                        rsp_denied_d = 1'b0;
                        wr_d         = req_write;
                        data_d       = req_write ? req_data : '0;
                    end
                end
            end
            ISSUE: state_d = wr_q ? RESP : WAIT;
            WAIT: begin
                rsp_data_d = reg_data_out;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d      = IDLE;
                    rsp_data_d   = '0;
                    rsp_denied_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            data_q       <= '0;
            rsp_data_q   <= '0;
            rsp_denied_q <= 1'b0;
            viol_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
            rsp_denied_q <= rsp_denied_d;
            viol_q       <= viol_d;
        end
    end

    // Register pins are only live in ISSUE; thread id toward the register is hard-wired to 0.
    assign req_ready     = (state_q == IDLE) && !rst;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_data      = rsp_data_q;
    assign rsp_denied    = rsp_denied_q;
    assign reg_access_en = (state_q == ISSUE);
    assign reg_wr_en     = (state_q == ISSUE) && wr_q;
    assign reg_thread_id = 1'b0;
    assign reg_data_in   = (state_q == ISSUE) ? data_q : '0;
    assign viol_count    = viol_q;
    assign locked        = lock_active;

endmodule

// File: tb/tb_secure_reg_access_master.sv
// Directed bench for secure_reg_access_master: vector table plus reset-in-ISSUE and counter/lockout sequences.
module tb_secure_reg_access_master;

    localparam int DW = 32;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write, req_thread_id;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_ready, rsp_denied;
    logic [DW-1:0] rsp_data;
    logic          reg_access_en, reg_wr_en, reg_thread_id;
    logic [DW-1:0] reg_data_in, reg_data_out;
    logic [VW-1:0] viol_count;
    logic          locked;
    logic [DW-1:0] cur_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    secure_reg_access_master #(.DATA_WIDTH(DW), .VIOL_CNT_WIDTH(VW), .LOCKOUT_THRESH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_thread_id(req_thread_id), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_denied(rsp_denied),
        .reg_access_en(reg_access_en), .reg_wr_en(reg_wr_en), .reg_thread_id(reg_thread_id),
        .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
        .viol_count(viol_count), .locked(locked)
    );

    // Register model: read data is only valid in the cycle after the strobe.
    always @(posedge clk) reg_data_out <= reg_access_en ? cur_rd : 32'hBAD0_BAD0;

    typedef struct {
        logic          wr;
        logic          tid;
        logic [DW-1:0] data;
        logic [DW-1:0] rd;
        int            stall;
        logic          den;
        int            lat;
        logic [DW-1:0] rdata;
        int            viol;
        logic          lck;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered just after a posedge with the DUT idle; returns at a negedge after the handshake.
    task automatic run_req(input vec_t v, input string nm);
        int cyc;
        int strobes;
        bit seen;
        logic [DW-1:0] held_data;
        logic held_den;
        @(posedge clk); #1;
        chk({nm, "/req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_write = v.wr; req_thread_id = v.tid; req_data = v.data;
        cur_rd = v.rd; rsp_ready = (v.stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = '0;
        cyc = 1; strobes = 0; seen = 0;
        while (!seen && cyc <= 8) begin
            @(negedge clk);
            if (reg_access_en) begin
                strobes++;
                chk({nm, "/reg_wr_en"}, reg_wr_en, v.wr);
                chk({nm, "/reg_data_in"}, reg_data_in, v.wr ? v.data : 32'h0);
                chk({nm, "/reg_thread_id"}, reg_thread_id, 1'b0);
            end
            if (rsp_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({nm, "/rsp_seen"}, seen, 1'b1);
        chk({nm, "/latency"}, cyc, v.lat);
        chk({nm, "/strobes"}, strobes, v.den ? 0 : 1);
        chk({nm, "/rsp_denied"}, rsp_denied, v.den);
        chk({nm, "/rsp_data"}, rsp_data, v.rdata);
        held_data = rsp_data; held_den = rsp_denied;
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_write = 1'b1; req_thread_id = 1'b0; req_data = 32'h55;
            @(negedge clk);
            chk({nm, "/stall_hold"}, {rsp_valid, rsp_denied, rsp_data, req_ready, reg_access_en},
                {1'b1, held_den, held_data, 1'b0, 1'b0});
        end
        if (v.stall > 0) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0; req_data = '0;
        @(negedge clk);
        chk({nm, "/post_idle"}, {rsp_valid, req_ready}, 2'b01);
        chk({nm, "/viol_count"}, viol_count, v.viol);
        chk({nm, "/locked"}, locked, v.lck);
    endtask

    initial begin
        vec_t v;
        int sat;
        bit lock_en;
`ifdef SECURE_REG_VIOLATION_LOCKOUT_EN
        lock_en = 1'b1;
`else
        lock_en = 1'b0;
`endif
        //             wr    tid   data          rd            stl den  lat rdata        viol lck
        vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        0, 1'b0, 2, 32'h0,        0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'hCAFEF00D, 32'h12345678, 0, 1'b0, 3, 32'h12345678, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        0, 1'b1, 1, 32'h0,        1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,        32'hA5A5A5A5, 5, 1'b0, 3, 32'hA5A5A5A5, 1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0,        32'h11111111, 3, 1'b1, 1, 32'h0,        2, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h01020304, 32'h0,        0, 1'b1, 1, 32'h0,        3, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0,        32'h22222222, 0, 1'b1, 1, 32'h0,        4, lock_en};
        if (lock_en)
            vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0BADF00D, 0, 1'b1, 1, 32'h0, 4, 1'b1};
        else
            vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0BADF00D, 0, 1'b0, 3, 32'h0BADF00D, 4, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_thread_id = 1'b0;
        req_data = '0; rsp_ready = 1'b0; cur_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {req_ready, rsp_valid, rsp_denied, rsp_data, reg_access_en, reg_wr_en,
                              reg_thread_id, reg_data_in, viol_count, locked}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release", {req_ready, rsp_valid, viol_count, locked}, {1'b1, 1'b0, 3'd0, 1'b0});

        for (int i = 0; i < 8; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // Reset landing in the ISSUE cycle of a granted write.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_thread_id = 1'b0; req_data = 32'h0000_0011;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_issue/pre", reg_access_en, lock_en ? 1'b0 : 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_issue/zero", {req_ready, rsp_valid, rsp_denied, rsp_data, reg_access_en, reg_wr_en,
                               reg_data_in, viol_count, locked}, '0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_issue/quiet", {rsp_valid, req_ready, reg_access_en}, 3'b010);
        end

        v = '{1'b0, 1'b0, 32'h0, 32'h600DCAFE, 0, 1'b0, 3, 32'h600DCAFE, 0, 1'b0};
        run_req(v, "post_rst_read");

        // Saturation (no lockout) or lockout-freeze of the violation counter.
        sat = lock_en ? 4 : 7;
        for (int i = 1; i <= 9; i++) begin
            v = '{1'b1, 1'b1, 32'hFFFF0000, 32'h0, 0, 1'b1, 1, 32'h0,
                  (i < sat) ? i : sat, lock_en && (i >= 4)};
            run_req(v, $sformatf("cnt%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
